// File: rtl/add8_seq_ctrl_pkg.sv
// Shared types and helpers for the multi-precision add/sub sequencer.
// State encodings are fixed; the unused code 2'd3 falls back to IDLE.
package add8_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Byte index width, never narrower than one bit so NBYTES=1 still has a register.
    function automatic int idx_w(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/add8_seq_ctrl_if.sv
// Request/result bundle between the ALU control path and the add/sub sequencer.
// master drives the operation request; slave returns status and result.
interface add8_seq_ctrl_if #(parameter int NBYTES = 4);

    localparam int W = 8 * NBYTES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );

endinterface

// File: rtl/add8_seq_ctrl_add8.sv
// Shared 8-bit ripple-carry adder datapath.
// Latency: combinational. Backpressure: none.
// Pure function of its inputs; the sequencer is its only user.
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    always_comb begin
        carry[0] = cin;
        sum      = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[8];
    end

endmodule

// File: rtl/add8_seq_ctrl.sv
// Multi-precision add/sub: streams NBYTES byte lanes LSB-first through one shared add8.
// Latency: accept at edge T -> done pulse in cycle T+NBYTES+1; one op per NBYTES+2 cycles.
// Backpressure: start is only honoured while busy=0; requests while busy are dropped.
module add8_seq_ctrl
    import add8_seq_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add8_seq_ctrl_if.slave       bus
);

    localparam int              W    = 8 * NBYTES;
    localparam int              IW   = idx_w(NBYTES);
    localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;       // already inverted for subtraction
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   result_q;
    logic           busy_q;
    logic           done_q;
    logic           cout_q;
    logic           ovf_q;

    logic [7:0]     lane_sum;
    logic           lane_cout;

    add8 u_add8 (
        .a    (a_q[8*idx +: 8]),
        .b    (b_q[8*idx +: 8]),
        .cin  (carry),
        .sum  (lane_sum),
        .cout (lane_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b ^ {W{bus.sub}};
                        carry    <= bus.sub;
                        idx      <= '0;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q[8*idx +: 8] <= lane_sum;
                    carry                <= lane_cout;
                    idx                  <= idx + 1'b1;
                    // Top lane: its sign bit decides signed overflow of the full word.
                    if (idx == LAST) begin
                        cout_q <= lane_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (lane_sum[7] != a_q[W-1]);
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Directed bench for add8_seq_ctrl with NBYTES=4; expected values are hand-computed.
module tb_add8_seq_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    add8_seq_ctrl_if #(.NBYTES(4)) bus ();

    add8_seq_ctrl #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for done (bounded), check latency, outputs and return to idle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] exp_res,
                         input logic exp_cout, input logic exp_ovf);
        int n;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        tick();
        chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
        chk({tag, "_held"}, bus.result, exp_res);
    endtask

    initial begin
        int pulses;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 32'h1111_1111;
        bus.b     = 32'h2222_2222;

        // Reset with start asserted: reset wins, nothing accepted.
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        do_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("t3", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("t4a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("t4b", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op("mix", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        do_op("eq", 32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Start pulsed while busy must be ignored; busy/done tracked per cycle.
        bus.a     = 32'h0000_0010;
        bus.b     = 32'h0000_0020;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        pulses    = 0;
        for (int j = 0; j < 8; j++) begin
            if (j == 1) begin
                bus.a     = 32'hAAAA_AAAA;
                bus.b     = 32'h5555_5555;
                bus.sub   = 1'b1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            chk($sformatf("t5_busy%0d", j), 32'(bus.busy), (j <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("t5_done%0d", j), 32'(bus.done), (j == 4) ? 32'd1 : 32'd0);
            if (bus.done) pulses++;
            tick();
        end
        bus.start = 1'b0;
        chk("t5_pulses", 32'(pulses), 32'd1);
        chk("t5_result", bus.result, 32'h0000_0030);

        // Reset in the middle of an op: aborts, clears outputs, no done.
        bus.a     = 32'h0101_0101;
        bus.b     = 32'h0101_0101;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("t6_partial", bus.result, 32'h0000_0202);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_result", bus.result, 32'h0);
        chk("t6_cout", 32'(bus.cout), 32'd0);
        chk("t6_ovf", 32'(bus.ovf), 32'd0);
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            if (bus.done) pulses++;
            tick();
        end
        chk("t6_no_done", 32'(pulses), 32'd0);
        do_op("t6_after", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

        // Start held high: not taken in DONE, taken on the following IDLE cycle.
        bus.a     = 32'h0000_0003;
        bus.b     = 32'h0000_0004;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("t7_done", 32'(bus.done), 32'd1);
        tick();
        chk("t7_idle_gap", 32'(bus.busy), 32'd0);
        bus.a = 32'h0000_0009;
        tick();
        bus.start = 1'b0;
        chk("t7_reaccept", 32'(bus.busy), 32'd1);
        for (int j = 0; j < 4; j++) tick();
        chk("t7_done2", 32'(bus.done), 32'd1);
        chk("t7_result2", bus.result, 32'h0000_000D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
